addsub_sat_stage: RTL

- Registered, saturating output stage directly downstream of the 16-bit two's-complement adder/subtractor in the ODE datapath.
- Captures the adder's combinational `result`/`overflow` pair under a valid/ready handshake and clamps overflowed sums to full-scale.
- Optionally accumulates successive clamped sums for integration steps.
- Buffers results in a small FIFO so the next solver stage can stall without stalling the adder's operand feed.

---
 rtl/addsub_pkg.sv | 43 ++++
 rtl/addsub_sat_stage_if.sv | 28 ++
 rtl/addsub_out_fifo.sv | 64 ++++++
 rtl/addsub_sat_stage.sv | 107 ++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and saturation helpers for the adder/subtractor output stage.
// The helpers are sized to DEFAULT_WIDTH, the width of the upstream adder.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [DEFAULT_WIDTH-1:0] SMAX = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_WIDTH-1:0] SMIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] value;
    logic                     sat;
  } sat_add_t;

  // An overflowed sum whose sign bit reads negative really overflowed positive.
  function automatic logic [DEFAULT_WIDTH-1:0] sat_clamp(
    input logic [DEFAULT_WIDTH-1:0] result,
    input logic                     overflow
  );
    logic [DEFAULT_WIDTH-1:0] r;
    r = result;
    if (overflow) r = result[DEFAULT_WIDTH-1] ? SMAX : SMIN;
    return r;
  endfunction

  function automatic sat_add_t sat_add(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b
  );
    sat_add_t                 r;
    logic [DEFAULT_WIDTH-1:0] sum;
    sum     = a + b;
    r.value = sum;
    r.sat   = 1'b0;
    if ((a[DEFAULT_WIDTH-1] == b[DEFAULT_WIDTH-1]) &&
        (sum[DEFAULT_WIDTH-1] != a[DEFAULT_WIDTH-1])) begin
      r.value = a[DEFAULT_WIDTH-1] ? SMIN : SMAX;
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_sat_stage_if.sv
// Handshake bundle between the adder, the saturating stage and the next solver stage.
// The slave modport is the stage's view; master is the surrounding environment.
interface addsub_sat_stage_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  modport slave (
    input  in_valid, in_result, in_overflow, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_result, in_overflow, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/addsub_out_fifo.sv
// Small circular FIFO; pointers wrap naturally because DEPTH is a power of two.
module addsub_out_fifo #(
  parameter  int DEPTH = 2,
  parameter  int DW    = 17,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/addsub_sat_stage.sv
// Registered saturating output stage behind the ODE adder/subtractor: clamp,
// optional accumulate, overflow bookkeeping and a small decoupling FIFO.
module addsub_sat_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              acc_en,
  addsub_sat_stage_if.slave bus,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic             accept, pop;
  logic [WIDTH-1:0] sat1, acc_base, stage_val;
  logic             stage_sat;
  sat_add_t         add_r;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_en_q, ready_en_d;
  logic [WIDTH:0]   hold_q, hold_d;

  logic [WIDTH:0]   fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // A clear on the same edge as an accept makes that element start from zero.
  always_comb begin
    sat1      = sat_clamp(bus.in_result, bus.in_overflow);
    acc_base  = clear ? '0 : acc_q;
    add_r     = sat_add(acc_base, sat1);
    stage_val = acc_en ? add_r.value : sat1;
    stage_sat = bus.in_overflow | (acc_en & add_r.sat);
  end

  always_comb begin
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    count_d    = count_q;
    ready_en_d = 1'b1;
    hold_d     = pop ? fifo_rdata : hold_q;
    if (clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      count_d  = '0;
    end
    if (accept) begin
      if (acc_en) acc_d = stage_val;
      if (stage_sat) begin
        sticky_d = 1'b1;
        if (count_d != '1) count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
      hold_q     <= hold_d;
    end
  end

  addsub_out_fifo #(
    .DEPTH (DEPTH),
    .DW    (WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept & ~fifo_full),
    .wdata ({stage_sat, stage_val}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The empty FIFO presents the last popped element so out_data never glitches.
  assign bus.in_ready                 = ready_en_q & (fifo_count < DEPTH_C);
  assign bus.out_valid                = ~fifo_empty;
  assign {bus.out_sat, bus.out_data}  = fifo_empty ? hold_q : fifo_rdata;
  assign ovf_sticky                   = sticky_q;
  assign ovf_count                    = count_q;

endmodule
